// File: rtl/uart_rx_framed.sv
// UART receiver with a 2-flop synchroniser, 3-sample majority vote, optional parity and 1/2 stop bits.
// Each received word is held on data/ready until the consumer takes it.
module uart_rx_framed #(
  parameter int WIDTH      = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 460800,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             can_receive_next_word,
  output logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overrun,
  output logic             busy
);

  localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int TW    = $clog2(TICKS);
  localparam int BW    = $clog2(WIDTH);

  localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);
  localparam logic [TW-1:0] T_V0   = TW'(TICKS / 2 - 1);
  localparam logic [TW-1:0] T_V1   = TW'(TICKS / 2);
  localparam logic [TW-1:0] T_V2   = TW'(TICKS / 2 + 1);
  localparam logic [BW-1:0] W_LAST = BW'(WIDTH - 1);
  localparam logic          S_LAST = (STOP_BITS == 2);

  if (TICKS < 8 || WIDTH < 5 || WIDTH > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_framed: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
  state_t state, state_n;

  logic             s1, s, s_prev;
  logic [TW-1:0]    t;
  logic             v0, v1;
  logic [BW-1:0]    bit_cnt;
  logic             stop_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_err, frame_acc;
  logic             t_end, vote_last, maj, commit;

  assign t_end     = (t == T_LAST);
  assign vote_last = (t == T_V2);
  // The third vote is the live synchronised sample; the first two were latched earlier.
  assign maj       = (v0 & v1) | (v0 & s) | (v1 & s);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      IDLE:      if (!s && s_prev) state_n = START;
      START:     if (vote_last && maj) state_n = IDLE;
                 else if (t_end) state_n = DATA;
      DATA:      if (t_end && bit_cnt == W_LAST) state_n = (PARITY != 0) ? PAR : STOP;
      PAR:       if (t_end) state_n = STOP;
      STOP:      if (vote_last && stop_cnt == S_LAST) begin
                   commit  = 1'b1;
                   state_n = maj ? IDLE : WAIT_HIGH;
                 end
      WAIT_HIGH: if (s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Handshake: ready=1 means data/error flags are valid; a rising edge with
  // ready & can_receive_next_word consumes the word, and nothing changes while it is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1            <= 1'b1;
      s             <= 1'b1;
      s_prev        <= 1'b1;
      t             <= '0;
      v0            <= 1'b0;
      v1            <= 1'b0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      shreg         <= '0;
      par_err       <= 1'b0;
      frame_acc     <= 1'b0;
      data          <= '0;
      ready         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      s1     <= signal;
      s      <= s1;
      s_prev <= s;
      if (state_n != state || t_end || state == IDLE || state == WAIT_HIGH) t <= '0;
      else t <= t + 1'b1;
      if (t == T_V0) v0 <= s;
      if (t == T_V1) v1 <= s;
      if (state == IDLE) begin
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        par_err   <= 1'b0;
        frame_acc <= 1'b0;
      end
      if (state == DATA && vote_last) shreg <= {maj, shreg[WIDTH-1:1]};
      if (state == DATA && t_end) bit_cnt <= (bit_cnt == W_LAST) ? '0 : bit_cnt + 1'b1;
      if (state == PAR && vote_last) par_err <= ((^shreg) ^ maj) != (PARITY == 2);
      if (state == STOP && vote_last && !maj) frame_acc <= 1'b1;
      if (state == STOP && t_end) stop_cnt <= 1'b1;
      overrun <= 1'b0;
      if (commit && (!ready || can_receive_next_word)) begin
        data          <= shreg;
        ready         <= 1'b1;
        parity_error  <= par_err;
        framing_error <= frame_acc | ~maj;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (ready && can_receive_next_word) begin
        ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: five instances (8N1 at 48 ticks, even/odd parity,
// two stop bits, and 8N1 at 8 ticks for the full byte sweep).
module tb_uart_rx_framed;

  localparam int PAR_P [5] = '{0, 1, 2, 0, 0};
  localparam int STOP_P[5] = '{1, 1, 1, 2, 1};
  localparam int CLK_P [5] = '{460800, 460800, 460800, 460800, 76800};

  localparam int LAT_8N1  = 461;  // 3 + 48*9  + 25, seen one negedge later
  localparam int LAT_LONG = 509;  // 3 + 48*10 + 25, seen one negedge later
  localparam int LAT_FAST = 81;   // 3 + 8*9   + 5,  seen one negedge later

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] line  = '1;
  logic [4:0] take  = '1;
  logic [7:0] data_v [5];
  logic [4:0] ready_v, pe_v, fe_v, ovr_v, busy_v;

  int passes = 0;
  int total  = 0;
  int cyc, rise_n, rise_cnt, ovr_n, ovr_at;
  logic       prev_rdy;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    uart_rx_framed #(
      .WIDTH(8), .BAUD_RATE(9600), .CLOCK_FREQ(CLK_P[g]),
      .PARITY(PAR_P[g]), .STOP_BITS(STOP_P[g])
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .signal(line[g]),
      .can_receive_next_word(take[g]),
      .data(data_v[g]),
      .ready(ready_v[g]),
      .parity_error(pe_v[g]),
      .framing_error(fe_v[g]),
      .overrun(ovr_v[g]),
      .busy(busy_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic mon_reset(input int ln);
    cyc = 0; rise_n = -1; rise_cnt = 0; ovr_n = 0; ovr_at = -1;
    prev_rdy = ready_v[ln];
  endtask

  // One clock of observation on lane ln, sampled at the falling edge.
  task automatic step(input int ln);
    @(negedge clock);
    cyc++;
    if (ready_v[ln] && !prev_rdy) begin
      rise_cnt++;
      if (rise_n < 0) begin
        rise_n = cyc; cap_data = data_v[ln]; cap_pe = pe_v[ln]; cap_fe = fe_v[ln];
      end
    end
    prev_rdy = ready_v[ln];
    if (ovr_v[ln]) begin
      if (ovr_n == 0) ovr_at = cyc;
      ovr_n++;
    end
  endtask

  task automatic drive(input int ln, input logic v, input int n);
    line[ln] = v;
    repeat (n) step(ln);
  endtask

  task automatic send_word(input int ln, input int tk, input logic [7:0] d, input bit has_par,
                           input logic p, input int nstop, input logic last_stop,
                           input int gap, input bit glitch);
    logic [15:0] b;
    int n;
    b = '0; b[8:1] = d; n = 9;
    if (has_par) begin b[n] = p; n++; end
    for (int i = 0; i < nstop; i++) begin b[n] = (i == nstop - 1) ? last_stop : 1'b1; n++; end
    mon_reset(ln);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < tk; k++) begin
        line[ln] = (glitch && k == tk / 2 + i % 3) ? ~b[i] : b[i];
        step(ln);
      end
    drive(ln, last_stop, gap);
  endtask

  task automatic expect_word(input string tag, input int rise, input logic [7:0] d,
                             input logic pe, input logic fe, input int ovr);
    check({tag, ".rise"}, rise_n, rise);
    check({tag, ".data"}, cap_data, d);
    check({tag, ".perr"}, cap_pe, pe);
    check({tag, ".ferr"}, cap_fe, fe);
    check({tag, ".ovr"}, ovr_n, ovr);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst%0d.data", i), data_v[i], 8'h00);
      check($sformatf("rst%0d.ready", i), ready_v[i], 1'b0);
      check($sformatf("rst%0d.busy", i), busy_v[i], 1'b0);
    end
    check("rst.flags", {pe_v[0], fe_v[0], ovr_v[0]}, 3'b000);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 8N1 at 48 ticks, including all-zero and all-one words
    send_word(0, 48, 8'h00, 0, 1'b0, 1, 1'b1, 30, 0); expect_word("w00", LAT_8N1, 8'h00, 0, 0, 0);
    send_word(0, 48, 8'hFF, 0, 1'b0, 1, 1'b1, 30, 0); expect_word("wff", LAT_8N1, 8'hFF, 0, 0, 0);
    send_word(0, 48, 8'hA3, 0, 1'b0, 1, 1'b1, 30, 0); expect_word("wa3", LAT_8N1, 8'hA3, 0, 0, 0);
    // one flipped vote sample per bit, rotating through all three positions
    send_word(0, 48, 8'hC3, 0, 1'b0, 1, 1'b1, 30, 1); expect_word("vote", LAT_8N1, 8'hC3, 0, 0, 0);

    for (int w = 0; w < 256; w++) begin
      send_word(4, 8, 8'(w), 0, 1'b0, 1, 1'b1, $urandom_range(24, 48), 0);
      expect_word($sformatf("sweep%0d", w), LAT_FAST, 8'(w), 0, 0, 0);
    end

    // short low glitch on an idle line
    mon_reset(0);
    drive(0, 1'b0, 20);
    check("glitch.busy_mid", busy_v[0], 1'b1);
    drive(0, 1'b1, 40);
    check("glitch.busy_after", busy_v[0], 1'b0);
    check("glitch.ready", ready_v[0], 1'b0);
    check("glitch.rises", rise_cnt, 0);

    // 0x07 has odd weight: even parity wants 1, odd parity wants 0
    send_word(1, 48, 8'h07, 1, 1'b1, 1, 1'b1, 40, 0); expect_word("even_ok", LAT_LONG, 8'h07, 0, 0, 0);
    send_word(1, 48, 8'h07, 1, 1'b0, 1, 1'b1, 40, 0); expect_word("even_bad", LAT_LONG, 8'h07, 1, 0, 0);
    send_word(2, 48, 8'h07, 1, 1'b0, 1, 1'b1, 40, 0); expect_word("odd_ok", LAT_LONG, 8'h07, 0, 0, 0);
    send_word(2, 48, 8'h07, 1, 1'b1, 1, 1'b1, 40, 0); expect_word("odd_bad", LAT_LONG, 8'h07, 1, 0, 0);

    // second stop bit low, then line held low
    send_word(3, 48, 8'hA5, 0, 1'b0, 2, 1'b0, 200, 0); expect_word("frame", LAT_LONG, 8'hA5, 0, 1, 0);
    check("frame.rises_low", rise_cnt, 1);
    check("frame.busy_low", busy_v[3], 1'b1);
    drive(3, 1'b1, 100);
    check("frame.rises_high", rise_cnt, 1);
    check("frame.busy_high", busy_v[3], 1'b0);
    send_word(3, 48, 8'h3C, 0, 1'b0, 2, 1'b1, 40, 0); expect_word("frame_next", LAT_LONG, 8'h3C, 0, 0, 0);

    // consumer stalled: second word dropped with a one-cycle overrun
    take[0] = 1'b0;
    send_word(0, 48, 8'h11, 0, 1'b0, 1, 1'b1, 40, 0); expect_word("hold1", LAT_8N1, 8'h11, 0, 0, 0);
    check("hold1.ready", ready_v[0], 1'b1);
    send_word(0, 48, 8'h22, 0, 1'b0, 1, 1'b1, 40, 0);
    check("ovr.rises", rise_cnt, 0);
    check("ovr.count", ovr_n, 1);
    check("ovr.at", ovr_at, LAT_8N1);
    check("ovr.data", data_v[0], 8'h11);
    check("ovr.ready", ready_v[0], 1'b1);
    take[0] = 1'b1;
    @(negedge clock);
    check("consume.ready", ready_v[0], 1'b0);
    check("consume.data", data_v[0], 8'h11);

    // reset in the middle of the data bits of 0x3C
    mon_reset(0);
    drive(0, 1'b0, 48);
    drive(0, 1'b0, 96);
    drive(0, 1'b1, 48);
    check("midrst.busy_before", busy_v[0], 1'b1);
    reset = 1'b1; line[0] = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst.data", data_v[0], 8'h00);
    check("midrst.ready", ready_v[0], 1'b0);
    check("midrst.busy", busy_v[0], 1'b0);
    check("midrst.flags", {pe_v[0], fe_v[0], ovr_v[0]}, 3'b000);
    drive(0, 1'b1, 60);
    check("midrst.no_word", rise_cnt, 0);
    send_word(0, 48, 8'h5A, 0, 1'b0, 1, 1'b1, 40, 0); expect_word("after_rst", LAT_8N1, 8'h5A, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
